// File: rtl/char_stream_pkg.sv
// Shared types for the character-stream sink: char width, entry layout,
// writer FSM states and the reader's EOF code.
package char_stream_pkg;

    localparam int CHAR_WIDTH = 8;

    typedef logic [CHAR_WIDTH-1:0] char_t;

    // One buffered stream element; 'last' marks the end of the stream.
    typedef struct packed {
        logic  last;
        char_t ch;
    } stream_entry_t;

    typedef enum logic [1:0] {
        STREAM,
        DRAIN,
        DONE
    } state_e;

    // A truncated read from the reader shows up as an all-ones char.
    localparam char_t EOF_CHAR = '1;

    // Chars the reader emits when it has nothing real to say.
    function automatic logic is_filler_char(input char_t c);
        return (c == '0) || (c == EOF_CHAR);
    endfunction

endpackage

// File: rtl/char_fifo.sv
// Show-ahead synchronous FIFO with occupancy count. The head entry is
// presented on rdata combinationally; push and pop may coincide when full.
module char_fifo #(
    parameter  int DEPTH = 8,
    parameter  int WIDTH = 9,
    localparam int AW    = $clog2(DEPTH),
    localparam int CW    = AW + 1
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic [WIDTH-1:0] rdata,
    output logic [CW-1:0]    count,
    output logic             full,
    output logic             empty
);

    localparam logic [CW-1:0] FULL_LVL = CW'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q,  count_d;

    // Next pointer and occupancy; pointers wrap naturally at the power-of-two depth.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) wr_ptr_d = wr_ptr_q + 1'b1;
        if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
        case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    // Pointer and count registers.
    always_ff @(posedge clock) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage write.
    // NOTE: the array is deliberately not reset; stale entries are never
    // visible because the consumer only looks at the head while count != 0.
    always_ff @(posedge clock) begin
        if (push) mem_q[wr_ptr_q] <= wdata;
    end

    assign rdata = mem_q[rd_ptr_q];
    assign count = count_q;
    assign full  = (count_q == FULL_LVL);
    assign empty = (count_q == '0);

endmodule

// File: rtl/char_stream_writer.sv
// Sink end of the reader's char stream: buffers chars in a FIFO, throttles
// the reader with pause, and replays the stream over valid/ready.
// Optional build macro CHAR_STREAM_WRITER_FILTER_EN drops 0x00 / all-ones
// chars before the FIFO (a last-flagged filler still leaves an end marker).
module char_stream_writer
    import char_stream_pkg::*;
#(
    parameter  int CHAR_WIDTH   = char_stream_pkg::CHAR_WIDTH,
    parameter  int DEPTH        = 8,
    parameter  int PAUSE_MARGIN = 2,
    localparam int CW           = $clog2(DEPTH) + 1
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  in_valid,
    input  logic [CHAR_WIDTH-1:0] in_char,
    input  logic                  in_last,
    output logic                  pause,
    output logic                  out_valid,
    output logic [CHAR_WIDTH-1:0] out_char,
    output logic                  out_last,
    input  logic                  out_ready,
    output logic                  has_finished,
    output logic                  overflow,
    output logic [CW-1:0]         count
);

    localparam logic [CW-1:0] PAUSE_LVL = CW'(DEPTH - PAUSE_MARGIN);

    state_e                state_q, state_d;
    logic                  overflow_q, overflow_d;
    logic                  fifo_push, fifo_pop, fifo_full, fifo_empty;
    logic [CHAR_WIDTH:0]   fifo_wdata, fifo_rdata;
    logic                  accept;
    logic [CHAR_WIDTH-1:0] store_char;
    logic                  want_push;

    // Decide whether the incoming char reaches the FIFO and what gets stored.
`ifdef CHAR_STREAM_WRITER_FILTER_EN
    logic filler;
    always_comb begin
        filler     = (in_char == '0) || (in_char == '1);
        accept     = !filler || in_last;
        store_char = filler ? '0 : in_char;
    end
`else
    always_comb begin
        accept     = 1'b1;
        store_char = in_char;
    end
`endif

    char_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (CHAR_WIDTH + 1)
    ) u_fifo (
        .clock (clock),
        .reset (reset),
        .push  (fifo_push),
        .wdata (fifo_wdata),
        .pop   (fifo_pop),
        .rdata (fifo_rdata),
        .count (count),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    // Handshake, push/overflow qualification, FSM next state and outputs.
    always_comb begin
        state_d    = state_q;
        overflow_d = overflow_q;

        out_valid  = (state_q != DONE) && !fifo_empty;
        out_char   = out_valid ? fifo_rdata[CHAR_WIDTH-1:0] : '0;
        out_last   = out_valid && fifo_rdata[CHAR_WIDTH];
        fifo_pop   = out_valid && out_ready;

        want_push  = in_valid && (state_q == STREAM) && accept;
        fifo_push  = want_push && (!fifo_full || fifo_pop);
        fifo_wdata = {in_last, store_char};

        if (want_push && fifo_full && !fifo_pop) overflow_d = 1'b1;

        case (state_q)
            STREAM:  if (fifo_push && in_last) state_d = DRAIN;
            DRAIN:   if (fifo_pop && out_last) state_d = DONE;
            default: state_d = DONE;
        endcase

        pause        = (count >= PAUSE_LVL) || (state_q == DONE);
        has_finished = (state_q == DONE);
        overflow     = overflow_q;
    end

    // FSM state and sticky overflow flag.
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples its _d value from before this edge.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q    <= STREAM;
            overflow_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            overflow_q <= overflow_d;
        end
    end

endmodule

// File: tb/tb_char_stream_writer.sv
// Directed bench for char_stream_writer: a queue-based stream model is
// compared against the DUT on every falling edge, and literal expectations
// pin the key points of each scenario.
module tb_char_stream_writer;

    localparam int DEPTH        = 8;
    localparam int PAUSE_MARGIN = 2;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       in_valid = 1'b0;
    logic [7:0] in_char  = '0;
    logic       in_last  = 1'b0;
    logic       out_ready = 1'b0;
    logic       pause, out_valid, out_last, has_finished, overflow;
    logic [7:0] out_char;
    logic [3:0] count;

    int total = 0;
    int bad   = 0;

    char_stream_writer #(
        .DEPTH        (DEPTH),
        .PAUSE_MARGIN (PAUSE_MARGIN)
    ) dut (
        .clock        (clock),
        .reset        (reset),
        .in_valid     (in_valid),
        .in_char      (in_char),
        .in_last      (in_last),
        .pause        (pause),
        .out_valid    (out_valid),
        .out_char     (out_char),
        .out_last     (out_last),
        .out_ready    (out_ready),
        .has_finished (has_finished),
        .overflow     (overflow),
        .count        (count)
    );

    always #5 clock = ~clock;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- stream model ----------------
    logic [8:0] mq[$];
    bit         m_fin  = 0;
    bit         m_last = 0;
    bit         m_ovf  = 0;
    bit         cmp_en = 0;

    always @(posedge clock) begin
        bit         popped;
        bit         do_push;
        bit         keep;
        logic [8:0] ent;
        logic [8:0] head;
        if (reset) begin
            mq.delete();
            m_fin  = 0;
            m_last = 0;
            m_ovf  = 0;
        end else begin
            popped  = !m_fin && (mq.size() != 0) && out_ready;
            do_push = 0;
            keep    = 1;
            ent     = {in_last, in_char};
`ifdef CHAR_STREAM_WRITER_FILTER_EN
            if (in_char == 8'h00 || in_char == 8'hFF) begin
                keep = in_last;
                ent  = {in_last, 8'h00};
            end
`endif
            if (in_valid && !m_last && !m_fin && keep) begin
                if (mq.size() < DEPTH || popped) do_push = 1;
                else                             m_ovf   = 1;
            end
            if (popped) begin
                head = mq.pop_front();
                if (head[8]) m_fin = 1;
            end
            if (do_push) begin
                mq.push_back(ent);
                if (ent[8]) m_last = 1;
            end
        end
        cmp_en = 1;
    end

    // Compare every DUT output with the model away from the rising edge.
    always @(negedge clock) begin
        bit         ev;
        logic [8:0] eh;
        if (cmp_en) begin
            ev = !m_fin && (mq.size() != 0);
            eh = ev ? mq[0] : 9'h000;
            check("m_out_valid", out_valid, ev);
            check("m_out_char", out_char, eh[7:0]);
            check("m_out_last", out_last, eh[8]);
            check("m_count", count, mq.size());
            check("m_pause", pause, m_fin || (mq.size() >= DEPTH - PAUSE_MARGIN));
            check("m_has_finished", has_finished, m_fin);
            check("m_overflow", overflow, m_ovf);
        end
    end

    // ---------------- stimulus ----------------
    task automatic step(input logic v, input logic [7:0] c, input logic l, input logic r);
        in_valid  = v;
        in_char   = c;
        in_last   = l;
        out_ready = r;
        @(posedge clock);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        step(0, 8'h00, 0, 0);
        reset = 1'b0;
    endtask

    initial begin
        // Reset state
        do_reset();
        check("rst_count", count, 0);
        check("rst_out_valid", out_valid, 0);
        check("rst_out_char", out_char, 0);
        check("rst_pause", pause, 0);
        check("rst_finished", has_finished, 0);
        check("rst_overflow", overflow, 0);

        // Basic flow: 'a','b','c'(last) with downstream always ready
        step(1, 8'h61, 0, 1);
        check("basic_a", out_char, 8'h61);
        step(1, 8'h62, 0, 1);
        check("basic_b", out_char, 8'h62);
        step(1, 8'h63, 1, 1);
        check("basic_c", out_char, 8'h63);
        check("basic_c_last", out_last, 1);
        check("basic_not_done", has_finished, 0);
        step(0, 8'h00, 0, 1);
        check("basic_done", has_finished, 1);
        check("basic_done_valid", out_valid, 0);
        check("basic_done_pause", pause, 1);

        // Backpressure up to full, then push+pop while full, then overflow
        do_reset();
        for (int i = 0; i < 6; i++) begin
            step(1, 8'h30 + 8'(i), 0, 0);
            if (i == 4) check("bp_pause_5", pause, 0);
        end
        check("bp_count_6", count, 6);
        check("bp_pause_6", pause, 1);
        step(1, 8'h36, 0, 0);
        step(1, 8'h37, 0, 0);
        check("bp_count_8", count, 8);
        check("bp_no_ovf", overflow, 0);
        step(1, 8'h38, 0, 1);
        check("full_pp_count", count, 8);
        check("full_pp_head", out_char, 8'h31);
        check("full_pp_no_ovf", overflow, 0);
        step(1, 8'h39, 0, 0);
        check("ovf_set", overflow, 1);
        check("ovf_count", count, 8);
        check("ovf_head", out_char, 8'h31);

        // Dropped last keeps STREAM; reset in DRAIN with count=3
        do_reset();
        for (int i = 0; i < 8; i++) step(1, 8'h40 + 8'(i), 0, 0);
        step(1, 8'h48, 1, 0);
        check("drop_last_ovf", overflow, 1);
        for (int i = 0; i < 5; i++) step(0, 8'h00, 0, 1);
        check("drain5_count", count, 3);
        check("drain5_head", out_char, 8'h45);
        step(1, 8'h49, 1, 1);
        check("late_last_count", count, 3);
        check("late_last_head", out_char, 8'h46);
        step(1, 8'h4A, 0, 0);
        check("drain_ignore", count, 3);
        do_reset();
        check("mid_rst_count", count, 0);
        check("mid_rst_valid", out_valid, 0);
        check("mid_rst_ovf", overflow, 0);
        check("mid_rst_fin", has_finished, 0);
        step(1, 8'h4B, 0, 0);
        check("mid_rst_stream", count, 1);
        check("mid_rst_head", out_char, 8'h4B);

        // Chars after last are never stored
        do_reset();
        step(1, 8'h78, 1, 0);
        step(1, 8'h79, 0, 0);
        step(1, 8'h7A, 0, 0);
        check("post_last_count", count, 1);
        check("post_last_head", out_char, 8'h78);
        check("post_last_flag", out_last, 1);
        step(0, 8'h00, 0, 1);
        check("post_last_done", has_finished, 1);
        check("post_last_empty", count, 0);
        step(1, 8'h71, 0, 1);
        check("done_ignore_count", count, 0);
        check("done_ignore_ovf", overflow, 0);
        check("done_sticky", has_finished, 1);

        // Filler chars 0x00 / 0xFF
        do_reset();
        step(1, 8'h00, 0, 0);
        step(1, 8'h41, 0, 0);
        step(1, 8'hFF, 1, 0);
`ifdef CHAR_STREAM_WRITER_FILTER_EN
        check("flt_count", count, 2);
        check("flt_head", out_char, 8'h41);
        step(0, 8'h00, 0, 1);
        check("flt_marker_valid", out_valid, 1);
        check("flt_marker_char", out_char, 8'h00);
        check("flt_marker_last", out_last, 1);
        step(0, 8'h00, 0, 1);
        check("flt_done", has_finished, 1);
`else
        check("nof_count", count, 3);
        check("nof_head_valid", out_valid, 1);
        check("nof_head", out_char, 8'h00);
        step(0, 8'h00, 0, 1);
        check("nof_second", out_char, 8'h41);
        step(0, 8'h00, 0, 1);
        check("nof_third", out_char, 8'hFF);
        check("nof_third_last", out_last, 1);
        step(0, 8'h00, 0, 1);
        check("nof_done", has_finished, 1);
`endif
        step(0, 8'h00, 0, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
